// File: rtl/datamem_responder.sv
// -----------------------------------------------------------------------------
// datamem_responder
//
// Multi-cycle data-memory target for the pipeline memory stage. It accepts one
// load/store request at a time over a valid/ready handshake. It holds the
// request for a fixed latency, then presents a response that stays stable
// until the initiator takes it. Storage is byte-addressed and little-endian.
// It supports byte, half and word accesses, with sign or zero extension for
// narrow loads. Misaligned or reserved-type accesses complete with rsp_err set.
// Such accesses leave storage untouched.
//
// Parameters
//   DATA_WIDTH   data/address width in bits (>= 32)
//   ADDR_WIDTH   byte-address bits actually decoded; storage is 2**ADDR_WIDTH B
//   LATENCY      accept edge to rsp_valid, 1..15
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid      request present
//   req_ready      responder idle and able to accept
//   req_write      1 = store, 0 = load
//   req_type       00 byte, 01 half, 10 word, 11 reserved
//   req_sign_ext   narrow loads: 1 = sign-extend, 0 = zero-extend
//   req_addr       byte address (upper bits above ADDR_WIDTH alias)
//   req_wdata      store data, right-aligned
//   rsp_valid      response present
//   rsp_ready      initiator accepts the response
//   rsp_rdata      load result; 0 for stores and errors
//   rsp_err        misaligned or reserved-type access
// -----------------------------------------------------------------------------
module datamem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_type,
  input  logic                  req_sign_ext,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01,
                            SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

  typedef struct packed {
    logic                  write;
    size_t                 kind;
    logic                  sign_ext;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } op_t;

  state_t                state, state_next;
  logic   [3:0]          cnt;
  op_t                   held;      // request captured on the accept edge
  op_t                   cur;       // request the commit logic operates on
  logic                  accept;
  logic                  commit;    // this edge enters RESP
  logic                  err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [7:0]            rb [4];
  logic [DATA_WIDTH-1:0] load_data;

  logic [7:0] mem [2**ADDR_WIDTH];

  // Address bits above the decoded range alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, req_addr[DATA_WIDTH-1:ADDR_WIDTH]};

  // Ready must be low while reset is held, even though state already reads IDLE.
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY == 1 the commit edge is the accept edge, so the live request
  // inputs are used instead of the (not yet loaded) held copy.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    cur          = held;
    if (state == IDLE) begin
      cur.write    = req_write;
      cur.kind     = size_t'(req_type);
      cur.sign_ext = req_sign_ext;
      cur.addr     = req_addr[ADDR_WIDTH-1:0];
      cur.wdata    = req_wdata;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_next = RESP;
        commit     = 1'b1;
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- decode
  assign idx = cur.addr;

  always_comb begin
    err = 1'b0;
    case (cur.kind)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = cur.addr[0];
      SZ_WORD: err = (cur.addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
  end

  // Byte lanes wrap within the decoded range; only the byte/half lanes that
  // the access actually uses matter, and aligned words never straddle the top.
  always_comb begin
    for (int k = 0; k < 4; k++) rb[k] = mem[idx + ADDR_WIDTH'(k)];
  end

  always_comb begin
    load_data = '0;
    case (cur.kind)
      SZ_BYTE: load_data = cur.sign_ext ? DATA_WIDTH'($signed(rb[0]))
                                        : DATA_WIDTH'(rb[0]);
      SZ_HALF: load_data = cur.sign_ext ? DATA_WIDTH'($signed({rb[1], rb[0]}))
                                        : DATA_WIDTH'({rb[1], rb[0]});
      SZ_WORD: load_data = DATA_WIDTH'({rb[3], rb[2], rb[1], rb[0]});
      default: load_data = '0;
    endcase
  end

  // ---------------------------------------------------------------- storage
  // NOTE: storage has no reset; contents persist across rst_n and a store
  // that has not reached its commit edge simply never writes.
  always_ff @(posedge clk) begin
    if (commit && cur.write && !err) begin
      mem[idx] <= cur.wdata[7:0];
      if (cur.kind != SZ_BYTE) mem[idx + ADDR_WIDTH'(1)] <= cur.wdata[15:8];
      if (cur.kind == SZ_WORD) begin
        mem[idx + ADDR_WIDTH'(2)] <= cur.wdata[23:16];
        mem[idx + ADDR_WIDTH'(3)] <= cur.wdata[31:24];
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      held      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        held <= cur;
        if (LATENCY > 1) cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_rdata <= (cur.write || err) ? '0 : load_data;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// -----------------------------------------------------------------------------
// tb_datamem_responder
//
// Self-checking bench for datamem_responder (LATENCY = 2). Directed vectors
// from a table, hand-written sequences for backpressure and reset corners,
// then randomized accesses checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_datamem_responder;

  localparam int LAT = 2;
  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_sign_ext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  datamem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic void ref_access(input logic w, input logic [1:0] t, input logic s,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic e);
    int n;
    int base;
    logic [31:0] v;
    n    = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    base = int'(a % MEM_BYTES);
    e    = (t == 2'd3) || ((a % n) != 0);
    rd   = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[(base + i) % MEM_BYTES] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(base + i) % MEM_BYTES]) << (8*i));
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endfunction

  // ------------------------------------------------------------ driver tasks
  // All tasks start and end just after a falling edge.
  task automatic send_req(input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] wd);
    int guard;
    req_write = w; req_type = t; req_sign_ext = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // lat counts falling edges from the accept cycle to the first rsp_valid.
  task automatic wait_rsp(input int stall, output logic [31:0] rd, output logic e,
                          output int lat);
    lat = 0;
    rsp_ready = (stall == 0);
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 50);
    rd = rsp_rdata;
    e  = rsp_err;
    if (!rsp_valid) begin
      check("rsp_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, rd);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic run_op(input logic w, input logic [1:0] t, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic e, output int lat);
    send_req(w, t, s, a, wd);
    wait_rsp(stall, rd, e, lat);
  endtask

  // Runs one access and compares it with the reference model.
  task automatic model_op(input string tag, input logic w, input logic [1:0] t,
                          input logic s, input logic [31:0] a, input logic [31:0] wd,
                          input int stall);
    logic [31:0] rd, erd;
    logic        e, ee;
    int          lat;
    ref_access(w, t, s, a, wd, erd, ee);
    run_op(w, t, s, a, wd, stall, rd, e, lat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 32'(e), 32'(ee));
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  t;
    logic        s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, erd, exp_rd;
    logic        e, ee;
    int          lat, guard;

    vecs.push_back('{"st_w_100",     1, 2'd2, 0, 32'h100,  32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{"ld_w_100",     0, 2'd2, 0, 32'h100,  32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"st_b_203",     1, 2'd0, 0, 32'h203,  32'h80,       32'h0,        0});
    vecs.push_back('{"ld_b_203_sx",  0, 2'd0, 1, 32'h203,  32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"ld_b_203_zx",  0, 2'd0, 0, 32'h203,  32'h0,        32'h00000080, 0});
    vecs.push_back('{"st_w_40",      1, 2'd2, 0, 32'h40,   32'h1234ABCD, 32'h0,        0});
    vecs.push_back('{"ld_h_42_zx",   0, 2'd1, 0, 32'h42,   32'h0,        32'h00001234, 0});
    vecs.push_back('{"ld_h_40_sx",   0, 2'd1, 1, 32'h40,   32'h0,        32'hFFFFABCD, 0});
    vecs.push_back('{"st_w_41_mis",  1, 2'd2, 0, 32'h41,   32'hFFFFFFFF, 32'h0,        1});
    vecs.push_back('{"ld_h_43_mis",  0, 2'd1, 1, 32'h43,   32'h0,        32'h0,        1});
    vecs.push_back('{"st_h_41_mis",  1, 2'd1, 0, 32'h41,   32'hFFFF,     32'h0,        1});
    vecs.push_back('{"st_rsvd_40",   1, 2'd3, 0, 32'h40,   32'h0,        32'h0,        1});
    vecs.push_back('{"ld_rsvd_40",   0, 2'd3, 0, 32'h40,   32'h0,        32'h0,        1});
    vecs.push_back('{"ld_w_40_kept", 0, 2'd2, 0, 32'h40,   32'h0,        32'h1234ABCD, 0});
    vecs.push_back('{"st_w_ffc",     1, 2'd2, 0, 32'hFFC,  32'hCAFEF00D, 32'h0,        0});
    vecs.push_back('{"ld_w_ffc",     0, 2'd2, 0, 32'hFFC,  32'h0,        32'hCAFEF00D, 0});
    vecs.push_back('{"ld_w_1ffc_al", 0, 2'd2, 0, 32'h1FFC, 32'h0,        32'hCAFEF00D, 0});
    vecs.push_back('{"ld_b_fff_sx",  0, 2'd0, 1, 32'hFFF,  32'h0,        32'hFFFFFFCA, 0});
    vecs.push_back('{"st_h_102",     1, 2'd1, 0, 32'h102,  32'h00008001, 32'h0,        0});
    vecs.push_back('{"ld_w_100_mix", 0, 2'd2, 0, 32'h100,  32'h0,        32'h8001BEEF, 0});
    vecs.push_back('{"ld_h_102_sx",  0, 2'd1, 1, 32'h102,  32'h0,        32'hFFFF8001, 0});

    // ---------------------------------------------------------- reset state
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // ---------------------------------------------------------- fill low 1 KiB
    for (int i = 0; i < 256; i++) model_op("fill", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0);

    // ---------------------------------------------------------- directed table
    foreach (vecs[i]) begin
      ref_access(vecs[i].w, vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].wd, erd, ee);
      run_op(vecs[i].w, vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].wd, 0, rd, e, lat);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].er);
      check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].ee));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
    end

    // ---------------------------------------------------------- backpressure
    ref_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, exp_rd, ee);
    send_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    rsp_ready = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      guard++;
    end while (!rsp_valid && guard < 50);
    check("bp_lat", 32'(guard), 32'(LAT));
    check("bp_rdata", rsp_rdata, exp_rd);
    // Second request waits on req_valid while the first response is held.
    req_write = 1'b0; req_type = 2'd2; req_sign_ext = 1'b0;
    req_addr = 32'h40; req_wdata = '0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_rdata_hold", rsp_rdata, exp_rd);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("bp_second_ready", 32'(req_ready), 32'd1);
    ref_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, erd, ee);
    wait_rsp(0, rd, e, lat);
    check("bp_second_rdata", rd, erd);
    check("bp_second_lat", 32'(lat), 32'(LAT));

    // ---------------------------------------------------------- reset in WAIT
    send_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h55);
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_in_wait", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rw_rsp_valid_held", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    model_op("rw_dropped", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0);

    // ---------------------------------------------------------- reset in RESP
    ref_access(1'b1, 2'd0, 1'b0, 32'h11, 32'h66, erd, ee);
    send_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h66);
    rsp_ready = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      guard++;
    end while (!rsp_valid && guard < 50);
    check("rr_in_resp", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    model_op("rr_committed", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);

    // ---------------------------------------------------------- random
    for (int i = 0; i < 300; i++) begin
      logic        w, s;
      logic [1:0]  t;
      logic [31:0] idx, a;
      int          n;
      w   = 1'($urandom % 2);
      s   = 1'($urandom % 2);
      t   = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      n   = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
      idx = $urandom_range(0, 1023);
      if ($urandom % 4 != 0) idx = idx & ~32'(n - 1);
      a   = ($urandom & 32'hFFFF_F000) | idx;
      model_op("rand", w, t, s, a, $urandom, int'($urandom % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/datamem_responder.md
Name: datamem_responder

Overview:
Multi-cycle data-memory target that answers load/store requests from the pipeline memory stage over a valid/ready request and response handshake. It holds byte-addressed little-endian storage and supports byte, half and word accesses with sign or zero extension. Each access has a fixed latency, so the bench and the hazard unit can exercise stall paths that a single-cycle memory never creates.

Parameters:
DATA_WIDTH, 32, data and address width in bits.
ADDR_WIDTH, 12, number of byte-address bits used; storage is 2**ADDR_WIDTH bytes.
LATENCY, 2, cycles from request accept edge to rsp_valid high; legal range 1..15.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_type  input  2  00 byte, 01 half, 10 word, 11 reserved.
req_sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  input  DATA_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  store data, right-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
rsp_err  output  1  misaligned or reserved-type access.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latency counter 0. req_ready is 0 while rst_n is low.
- Storage contents are not reset. The bench initialises memory by issuing writes.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE), derived combinationally from registered state.
- IDLE: on req_valid && req_ready, latch write, type, sign_ext, addr and wdata.
  - LATENCY == 1: go to RESP.
  - LATENCY > 1: load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge. rsp_valid is therefore high exactly LATENCY cycles after the accept edge.
- Commit point: the store write and the load read both occur on the edge that enters RESP. rsp_rdata and rsp_err are registered on that same edge.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready; then return to IDLE and clear rsp_valid.
  - No accept is possible in the RESP-exit cycle. Maximum throughput is one access per LATENCY+1 cycles.
- Addressing: byte index = addr[ADDR_WIDTH-1:0]. Higher address bits are ignored (aliasing wrap).
  - A word at the top aligned address does not wrap mid-word, because word accesses are aligned.
- Alignment:
  - Half with addr[0] = 1: error.
  - Word with addr[1:0] != 0: error.
  - req_type 11: error.
  - On error: no storage write, rsp_rdata = 0, rsp_err = 1. Latency is unchanged.
- Stores:
  - Byte writes wdata[7:0] to addr.
  - Half writes wdata[15:0] to addr and addr+1, little-endian.
  - Word writes four bytes, little-endian.
  - rsp_rdata = 0 for stores.
- Loads:
  - Byte/half fills the upper bits with the MSB of the loaded value when sign_ext = 1, otherwise with 0.
  - Word ignores sign_ext.
- Request inputs are ignored outside IDLE. A request held during WAIT or RESP is accepted only on its first IDLE cycle.
- Reset mid-operation: return to IDLE immediately.
  - A store still in WAIT is dropped and storage is unchanged.
  - A store already committed (in RESP) stays written.
  - rsp_valid drops asynchronously.

Test Plan:
- LATENCY = 2: store word 0xDEADBEEF @0x100, then load word @0x100 → rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF, rsp_err 0.
- Store byte 0x80 @0x203, then load byte with sign_ext 1 → 0xFFFFFF80; same load with sign_ext 0 → 0x00000080.
- Store word 0x1234ABCD @0x40, then load half @0x42 with sign_ext 0 → 0x00001234; load half @0x40 with sign_ext 1 → 0xFFFFABCD.
- Store word @0x41, then load half @0x43 → both rsp_err 1, rsp_rdata 0; a following word load @0x40 shows memory unchanged.
- Backpressure: hold rsp_ready 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready 0 throughout; a second request waiting on req_valid is accepted the cycle after the handshake.
- Assert rst_n low during WAIT of a store of 0x55 @0x10 → rsp_valid 0 and req_ready 0 immediately; after release, load @0x10 returns its pre-store value.
